// File: rtl/branch_sequencer.sv
// Instruction address offset queue sequencer with delayed-branch and
// nullify handling; conditional branches stall fetch until the compare resolves.
module branch_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       LE,
  input  logic       br_valid,
  input  logic       br_bl,
  input  logic       br_comb,
  input  logic       br_n,
  input  logic       br_neg,
  input  logic [7:0] TA,
  input  logic       cond_valid,
  input  logic       cond_true,
  output logic [7:0] IAOQ_FRONT,
  output logic [7:0] IAOQ_BACK,
  output logic       nullify,
  output logic       busy
);

  typedef enum logic {SEQ, RESOLVE} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_front, r_back, r_ta;
  logic       r_null, r_n, r_neg;

  logic [7:0] w_front_nxt, w_back_nxt, w_ta_nxt, w_back_inc;
  logic       w_null_nxt, w_n_nxt, w_neg_nxt;
  logic       w_br_ok;

  assign w_back_inc = r_back + 8'd4;
  // A branch sitting in the nullified delay slot never takes effect.
  assign w_br_ok    = br_valid & ~r_null;

  always_comb begin
    w_state_nxt = r_state;
    w_front_nxt = r_front;
    w_back_nxt  = r_back;
    w_null_nxt  = r_null;
    w_ta_nxt    = r_ta;
    w_n_nxt     = r_n;
    w_neg_nxt   = r_neg;
    if (LE) begin
      case (r_state)
        SEQ: begin
          if (w_br_ok && br_bl) begin
            w_front_nxt = r_back;
            w_back_nxt  = TA;
            w_null_nxt  = br_n;
          end else if (w_br_ok && br_comb) begin
            w_ta_nxt    = TA;
            w_n_nxt     = br_n;
            w_neg_nxt   = br_neg;
            w_null_nxt  = 1'b0;
            w_state_nxt = RESOLVE;
          end else begin
            w_front_nxt = r_back;
            w_back_nxt  = w_back_inc;
            w_null_nxt  = 1'b0;
          end
        end
        RESOLVE: begin
          if (cond_valid) begin
            w_front_nxt = r_back;
            w_back_nxt  = cond_true ? r_ta : w_back_inc;
            // Forward-taken / backward-not-taken skip the delay slot.
            w_null_nxt  = r_n & (cond_true ^ r_neg);
            w_state_nxt = SEQ;
          end
        end
        default: w_state_nxt = SEQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEQ;
      r_front <= 8'h00;
      r_back  <= 8'h04;
      r_null  <= 1'b0;
      r_ta    <= 8'h00;
      r_n     <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_front <= w_front_nxt;
      r_back  <= w_back_nxt;
      r_null  <= w_null_nxt;
      r_ta    <= w_ta_nxt;
      r_n     <= w_n_nxt;
      r_neg   <= w_neg_nxt;
    end
  end

  assign IAOQ_FRONT = r_front;
  assign IAOQ_BACK  = r_back;
  assign nullify    = r_null;
  assign busy       = (r_state == RESOLVE);

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized and directed bench for branch_sequencer against a behavioural
// model of the issue stream (front/back addresses, pending branch, nullify).
module tb_branch_sequencer;

  logic       clk = 1'b0;
  logic       reset, LE, br_valid, br_bl, br_comb, br_n, br_neg;
  logic [7:0] TA;
  logic       cond_valid, cond_true;
  logic [7:0] IAOQ_FRONT, IAOQ_BACK;
  logic       nullify, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [7:0] m_front, m_back, m_ta;
  logic       m_null, m_pend, m_n, m_neg;

  always #5 clk = ~clk;

  branch_sequencer dut (
    .clk(clk), .reset(reset), .LE(LE), .br_valid(br_valid), .br_bl(br_bl),
    .br_comb(br_comb), .br_n(br_n), .br_neg(br_neg), .TA(TA),
    .cond_valid(cond_valid), .cond_true(cond_true),
    .IAOQ_FRONT(IAOQ_FRONT), .IAOQ_BACK(IAOQ_BACK), .nullify(nullify), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic rst, input logic le, input logic bv, input logic bl,
                        input logic cb, input logic n, input logic neg, input logic [7:0] ta,
                        input logic cv, input logic ct);
    reset = rst; LE = le; br_valid = bv; br_bl = bl; br_comb = cb;
    br_n = n; br_neg = neg; TA = ta; cond_valid = cv; cond_true = ct;
  endtask

  // Model update from the spec rules, applied at each rising edge.
  task automatic model_step();
    logic [7:0] nb;
    if (reset) begin
      m_front = 8'h00; m_back = 8'h04; m_null = 1'b0;
      m_pend = 1'b0; m_ta = 8'h00; m_n = 1'b0; m_neg = 1'b0;
    end else if (LE) begin
      if (!m_pend) begin
        if (br_valid && !m_null && br_bl) begin
          m_front = m_back; m_back = TA; m_null = br_n;
        end else if (br_valid && !m_null && br_comb) begin
          m_ta = TA; m_n = br_n; m_neg = br_neg; m_pend = 1'b1; m_null = 1'b0;
        end else begin
          m_front = m_back; m_back = m_back + 8'd4; m_null = 1'b0;
        end
      end else if (cond_valid) begin
        nb = cond_true ? m_ta : m_back + 8'd4;
        m_null  = m_n && (cond_true != m_neg);
        m_front = m_back; m_back = nb; m_pend = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("front", IAOQ_FRONT, m_front);
    chk("back", IAOQ_BACK, m_back);
    chk("nullify", nullify, m_null);
    chk("busy", busy, m_pend);
  endtask

  task automatic do_reset();
    set_in(1, 0, 1, 1, 1, 1, 1, 8'hFF, 1, 1);
    tick();
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 1);
      tick();
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    m_front = 0; m_back = 0; m_null = 0; m_pend = 0; m_ta = 0; m_n = 0; m_neg = 0;
    #2;
    do_reset();
    chk("rst_front", IAOQ_FRONT, 8'h00);
    chk("rst_back", IAOQ_BACK, 8'h04);
    chk("rst_busy", busy, 1'b0);

    // sequential wrap
    for (int i = 1; i <= 64; i++) begin
      seq(1);
      chk("wrap_step", IAOQ_FRONT, (i * 4) % 256);
    end
    chk("wrap_front", IAOQ_FRONT, 8'h00);
    chk("wrap_back", IAOQ_BACK, 8'h04);

    // BL with nullify, then a branch in the nullified slot is ignored
    seq(4);
    chk("bl_pre", IAOQ_FRONT, 8'h10);
    set_in(0, 1, 1, 1, 0, 1, 0, 8'h40, 0, 0); tick();
    chk("bl_front", IAOQ_FRONT, 8'h14);
    chk("bl_back", IAOQ_BACK, 8'h40);
    chk("bl_null", nullify, 1'b1);
    set_in(0, 1, 1, 1, 0, 1, 0, 8'h99, 0, 0); tick();
    chk("bl2_front", IAOQ_FRONT, 8'h40);
    chk("bl2_back", IAOQ_BACK, 8'h44);
    chk("bl2_null", nullify, 1'b0);

    // COMB backward, n=1, taken then not taken
    for (int ct = 1; ct >= 0; ct--) begin
      do_reset(); seq(8);
      chk("comb_pre", IAOQ_FRONT, 8'h20);
      set_in(0, 1, 1, 0, 1, 1, 1, 8'h08, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
        set_in(0, 1, 1, 1, 0, 0, 0, 8'hCC, 0, 0); tick();
        chk("comb_busy", busy, 1'b1);
        chk("comb_hold", IAOQ_FRONT, 8'h20);
      end
      set_in(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, ct[0]); tick();
      chk("res_front", IAOQ_FRONT, 8'h24);
      chk("res_back", IAOQ_BACK, ct ? 8'h08 : 8'h28);
      chk("res_null", nullify, ct ? 1'b0 : 1'b1);
      chk("res_busy", busy, 1'b0);
    end

    // stall hold in SEQ and in RESOLVE
    do_reset(); seq(3);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 1, 1, 0, 1, 0, 8'h77, 1, 1); tick();
      chk("stall_seq", IAOQ_FRONT, 8'h0C);
    end
    set_in(0, 1, 1, 0, 1, 1, 0, 8'h60, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 1); tick();
      chk("stall_res", busy, 1'b1);
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 8'h00, 1, 1); tick();
    chk("fwd_taken_null", nullify, 1'b1);
    chk("fwd_taken_back", IAOQ_BACK, 8'h60);

    // priority BL over COMB, then reset abandons pending branch
    set_in(0, 1, 1, 1, 1, 0, 0, 8'h30, 0, 0); tick(); // in nullified slot: ignored
    set_in(0, 1, 1, 1, 1, 0, 0, 8'h30, 0, 0); tick();
    chk("prio_busy", busy, 1'b0);
    chk("prio_back", IAOQ_BACK, 8'h30);
    set_in(0, 1, 1, 0, 1, 0, 0, 8'hA0, 0, 0); tick();
    chk("pend_busy", busy, 1'b1);
    set_in(1, 1, 0, 0, 0, 0, 0, 8'h00, 1, 1); tick();
    chk("rres_front", IAOQ_FRONT, 8'h00);
    chk("rres_back", IAOQ_BACK, 8'h04);
    chk("rres_busy", busy, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 0), 1'($urandom), 1'($urandom),
             8'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
